// File: rtl/ir_decoder_multi.sv
// NEC-style IR frame decoder: synchroniser, glitch filter, pulse-length counter and frame FSM
// States: IDLE 0 wait sync fall | SYNC_B 1 sync burst | SYNC_S 2 sync silence | BIT_B 3 bit burst | BIT_S 4 bit silence | REP_B 5 repeat burst | CHECK 6 validate word
module ir_decoder_multi #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned INV_CHECK = 1,
  parameter int unsigned SBD       = 1_212_121,
  parameter int unsigned SSD       = 606_060,
  parameter int unsigned RSD       = 303_030,
  parameter int unsigned BBD       = 80_808,
  parameter int unsigned BSD0      = 80_808,
  parameter int unsigned BSD1      = 215_488,
  parameter int unsigned MARGIN    = 20_000,
  parameter int unsigned FILT      = 4,
  parameter int unsigned REP_WIN   = 14_814_814
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             signal_in,
  output logic [NBITS-1:0] code_out,
  output logic             new_code_out,
  output logic             repeat_out,
  output logic [2:0]       error_out,
  output logic [3:0]       state_out
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SYNC_B = 4'd1,
    SYNC_S = 4'd2,
    BIT_B  = 4'd3,
    BIT_S  = 4'd4,
    REP_B  = 4'd5,
    CHECK  = 4'd6
  } state_t;

  localparam int unsigned CW = $clog2(NBITS + 1);
  localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q;
  logic [31:0]   len_q;
  logic          edge_w, fall_w;

  assign edge_w = (sync2_q != filt_q) && (fcnt_q == FW'(FILT - 1));
  assign fall_w = edge_w && filt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      len_q   <= '0;
    end else begin
      sync1_q <= signal_in;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (edge_w) begin
        fcnt_q <= '0;
        filt_q <= ~filt_q;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
      // Length includes the first cycle of the new level, so L equals the level duration
      if (edge_w)           len_q <= 32'd1;
      else if (len_q != '1) len_q <= len_q + 32'd1;
    end
  end

  function automatic logic in_win(input logic [31:0] l, input logic [31:0] x);
    logic [32:0] lw, xw;
    lw = {1'b0, l};
    xw = {1'b0, x};
    return (lw + 33'(MARGIN) >= xw) && (lw <= xw + 33'(MARGIN));
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d, code_q, code_d;
  logic             new_code_q, new_code_d, repeat_q, repeat_d, have_q, have_d;
  logic [2:0]       err_q, err_d;
  logic [31:0]      hold_q, hold_d, w32;
  logic             inv_ok, raise, bitv;
  logic [2:0]       raise_code;

  assign w32    = 32'(shreg_q);
  assign inv_ok = (w32[15:8] == ~w32[7:0]) && (w32[31:24] == ~w32[23:16]);

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    code_d     = code_q;
    new_code_d = 1'b0;
    repeat_d   = 1'b0;
    err_d      = err_q;
    have_d     = have_q;
    hold_d     = hold_q;
    raise      = 1'b0;
    raise_code = 3'd0;
    bitv       = 1'b0;
    if (have_q && hold_q != '1) hold_d = hold_q + 32'd1;
    case (state_q)
      IDLE: if (fall_w) begin
        state_d = SYNC_B;
        err_d   = 3'd0;
        bcnt_d  = '0;
        shreg_d = '0;
      end
      SYNC_B: if (edge_w) begin
        if (in_win(len_q, SBD)) state_d = SYNC_S;
        else begin raise = 1'b1; raise_code = 3'd1; end
      end else if (len_q > SBD + MARGIN) begin
        raise = 1'b1; raise_code = 3'd1;
      end
      SYNC_S: if (edge_w) begin
        if (in_win(len_q, SSD))      state_d = BIT_B;
        else if (in_win(len_q, RSD)) state_d = REP_B;
        else begin raise = 1'b1; raise_code = 3'd2; end
      end else if (len_q > SSD + MARGIN) begin
        raise = 1'b1; raise_code = 3'd2;
      end
      BIT_B: if (edge_w) begin
        if (in_win(len_q, BBD)) state_d = BIT_S;
        else begin raise = 1'b1; raise_code = 3'd3; end
      end else if (len_q > BBD + MARGIN) begin
        raise = 1'b1; raise_code = 3'd3;
      end
      BIT_S: if (edge_w) begin
        if (in_win(len_q, BSD0) || in_win(len_q, BSD1)) begin
          bitv = !in_win(len_q, BSD0);
          if (LSB_FIRST != 0) shreg_d = {bitv, shreg_q[NBITS-1:1]};
          else                shreg_d = {shreg_q[NBITS-2:0], bitv};
          bcnt_d  = bcnt_q + CW'(1);
          state_d = (bcnt_q == CW'(NBITS - 1)) ? CHECK : BIT_B;
        end else begin
          raise = 1'b1; raise_code = 3'd4;
        end
      end else if (len_q > BSD1 + MARGIN) begin
        raise = 1'b1; raise_code = 3'd4;
      end
      CHECK: begin
        if (INV_CHECK != 0 && NBITS == 32 && !inv_ok) begin
          raise = 1'b1; raise_code = 3'd5;
        end else begin
          code_d     = shreg_q;
          new_code_d = 1'b1;
          have_d     = 1'b1;
          hold_d     = '0;
          state_d    = IDLE;
        end
      end
      REP_B: if (edge_w) begin
        if (!in_win(len_q, BBD)) begin
          raise = 1'b1; raise_code = 3'd3;
        end else if (have_q && hold_q <= REP_WIN) begin
          repeat_d = 1'b1;
          hold_d   = '0;
          state_d  = IDLE;
        end else begin
          raise = 1'b1; raise_code = 3'd6;
        end
      end else if (len_q > BBD + MARGIN) begin
        raise = 1'b1; raise_code = 3'd3;
      end
      default: state_d = IDLE;
    endcase
    if (raise) begin
      err_d   = raise_code;
      have_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      code_q     <= '0;
      new_code_q <= 1'b0;
      repeat_q   <= 1'b0;
      err_q      <= 3'd0;
      have_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      code_q     <= code_d;
      new_code_q <= new_code_d;
      repeat_q   <= repeat_d;
      err_q      <= err_d;
      have_q     <= have_d;
      hold_q     <= hold_d;
    end
  end

  assign code_out     = code_q;
  assign new_code_out = new_code_q;
  assign repeat_out   = repeat_q;
  assign error_out    = err_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_ir_decoder_multi.sv
// Directed bench for ir_decoder_multi: an MSB-first and an LSB-first decoder share one IR line.
module tb_ir_decoder_multi;

  localparam logic [31:0] GOOD = 32'h00FF20DF;
  localparam logic [31:0] BAD  = 32'h00FF20DE;

  logic        clk, rst_n, signal_in;
  logic [31:0] code_m, code_l;
  logic        new_m, new_l, rep_m, rep_l;
  logic [2:0]  err_m, err_l;
  logic [3:0]  state_m, state_l;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        rep;
    logic [31:0] code;
    logic [31:0] lcode;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_pulse = 1'b0;
  int   maxst;

  ir_decoder_multi #(.NBITS(32), .LSB_FIRST(0), .INV_CHECK(1), .SBD(100), .SSD(50), .RSD(25),
    .BBD(10), .BSD0(10), .BSD1(30), .MARGIN(3), .FILT(2), .REP_WIN(2000)) dut_m (
    .clk_in(clk), .rst_n_in(rst_n), .signal_in(signal_in), .code_out(code_m),
    .new_code_out(new_m), .repeat_out(rep_m), .error_out(err_m), .state_out(state_m));

  ir_decoder_multi #(.NBITS(32), .LSB_FIRST(1), .INV_CHECK(1), .SBD(100), .SSD(50), .RSD(25),
    .BBD(10), .BSD0(10), .BSD1(30), .MARGIN(3), .FILT(2), .REP_WIN(2000)) dut_l (
    .clk_in(clk), .rst_n_in(rst_n), .signal_in(signal_in), .code_out(code_l),
    .new_code_out(new_l), .repeat_out(rep_l), .error_out(err_l), .state_out(state_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  task automatic seg(input logic lvl, input int n);
    signal_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sync(input int silence);
    seg(1'b0, 100);
    seg(1'b1, silence);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      seg(1'b0, 10);
      seg(1'b1, w[31-i] ? 30 : 10);
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_sync(50);
    send_bits(w, 32);
    seg(1'b0, 10);
    seg(1'b1, 20);
  endtask

  task automatic send_repeat();
    send_sync(25);
    seg(1'b0, 10);
    seg(1'b1, 20);
  endtask

  task automatic push_code(input logic [31:0] w);
    exp_q.push_back('{rep: 1'b0, code: w, lcode: rev32(w)});
  endtask

  task automatic push_rep();
    exp_q.push_back('{rep: 1'b1, code: 32'h0, lcode: 32'h0});
  endtask

  // Scoreboard: every output pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (new_m || rep_m) begin
      chk("pulse_exclusive", 32'(new_m & rep_m), 32'd0);
      chk("pulse_single_cycle", 32'(prev_pulse), 32'd0);
      chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", 32'(rep_m), 32'(mon_e.rep));
        chk("lsb_pulse_match", 32'({new_l, rep_l}), 32'({new_m, rep_m}));
        if (!mon_e.rep) begin
          chk("code_msb", code_m, mon_e.code);
          chk("code_lsb", code_l, mon_e.lcode);
        end
      end
    end
    prev_pulse = new_m | rep_m;
  end

  initial begin
    rst_n = 1'b0;
    signal_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("in_reset_code", code_m, 32'd0);
    chk("in_reset_state", 32'(state_m), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_code_m", code_m, 32'd0);
    chk("reset_code_l", code_l, 32'd0);
    chk("reset_err", 32'(err_m), 32'd0);
    chk("reset_state", 32'(state_m), 32'd0);
    chk("reset_pulses", 32'({new_m, rep_m, new_l, rep_l}), 32'd0);

    signal_in = 1'b0;
    @(negedge clk);
    signal_in = 1'b1;
    maxst = 0;
    repeat (10) begin
      @(negedge clk);
      if (int'(state_m) > maxst) maxst = int'(state_m);
    end
    chk("glitch_state", 32'(maxst), 32'd0);

    push_code(GOOD);
    send_frame(GOOD);
    chk("good_drain", 32'(exp_q.size()), 32'd0);
    chk("good_code", code_m, GOOD);
    chk("good_err", 32'(err_m), 32'd0);
    chk("good_state", 32'(state_m), 32'd0);

    seg(1'b1, 480);
    push_rep();
    send_repeat();
    chk("repeat_drain", 32'(exp_q.size()), 32'd0);
    chk("repeat_err", 32'(err_m), 32'd0);

    seg(1'b1, 2500);
    send_repeat();
    chk("late_repeat_err_m", 32'(err_m), 32'd6);
    chk("late_repeat_err_l", 32'(err_l), 32'd6);

    push_code(GOOD);
    send_frame(GOOD);
    chk("good2_drain", 32'(exp_q.size()), 32'd0);
    send_frame(BAD);
    chk("bad_err_m", 32'(err_m), 32'd5);
    chk("bad_err_l", 32'(err_l), 32'd5);
    chk("bad_code_kept_m", code_m, GOOD);
    chk("bad_code_kept_l", code_l, rev32(GOOD));
    chk("bad_state", 32'(state_m), 32'd0);

    seg(1'b0, 100);
    chk("long_sync_mid_state", 32'(state_m), 32'd1);
    chk("long_sync_mid_err", 32'(err_m), 32'd0);
    seg(1'b0, 10);
    chk("long_sync_err", 32'(err_m), 32'd1);
    chk("long_sync_state", 32'(state_m), 32'd0);
    seg(1'b1, 20);
    chk("long_sync_after_state", 32'(state_m), 32'd0);

    send_sync(50);
    send_bits(GOOD, 4);
    seg(1'b0, 10);
    seg(1'b1, 20);
    seg(1'b0, 10);
    seg(1'b1, 20);
    chk("bit_silence_err", 32'(err_m), 32'd4);
    chk("bit_silence_state", 32'(state_m), 32'd0);

    send_sync(50);
    send_bits(GOOD, 17);
    chk("pre_reset_state", 32'(state_m), 32'd4);
    signal_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_code", code_m, 32'd0);
    chk("async_rst_code_l", code_l, 32'd0);
    chk("async_rst_state", 32'({state_m, state_l}), 32'd0);
    chk("async_rst_err", 32'({err_m, err_l}), 32'd0);
    chk("async_rst_pulses", 32'({new_m, rep_m, new_l, rep_l}), 32'd0);
    repeat (3) @(negedge clk);
    signal_in = 1'b1;
    rst_n = 1'b1;
    seg(1'b1, 10);
    chk("post_reset_state", 32'(state_m), 32'd0);

    send_repeat();
    chk("repeat_after_reset_err", 32'(err_m), 32'd6);

    push_code(GOOD);
    send_frame(GOOD);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    chk("final_code", code_m, GOOD);
    chk("final_err", 32'(err_m), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_decoder_multi.md
# ir_decoder_multi

Parametrised successor to the NEC-style IR frame decoder. Takes the raw demodulated IR receiver line (idle high, burst low) and conditions it internally with a synchroniser, glitch filter and pulse-width counter. It decodes frames of configurable bit count and bit order, validates NEC address/command inverse bytes, and recognises NEC repeat frames within a hold window. It sits between the IR receiver pin and the command dispatch logic.

## Interface
- NBITS, 32: data bits per frame (8..32)
- LSB_FIRST, 0: 1 = first received bit lands in bit 0; 0 = shift-left, first bit ends in bit NBITS-1
- INV_CHECK, 1: 1 = enforce code[15:8]==~code[7:0] and code[31:24]==~code[23:16]; ignored unless NBITS==32
- SBD, 1_212_121: sync burst length (cycles)
- SSD, 606_060: sync silence length, data frame
- RSD, 303_030: sync silence length, repeat frame
- BBD, 80_808: bit burst length
- BSD0, 80_808 / BSD1, 215_488: bit silence length for 0 / 1
- MARGIN, 20_000: inclusive ± tolerance on every length
- FILT, 4: consecutive equal samples required to change filtered level
- REP_WIN, 14_814_814: max cycles from last accepted code/repeat to a valid repeat completion
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- signal_in  in  1  raw IR line, async to clk_in
- code_out  out  NBITS  last accepted code
- new_code_out  out  1  one-cycle pulse, code_out just updated
- repeat_out  out  1  one-cycle pulse, valid repeat frame for held code
- error_out  out  3  last error code, sticky until next sync start
- state_out  out  4  current FSM state encoding

## Operation
- Conditioning: 2-flop synchroniser, then filter; filtered level (reset 1) changes only after FILT consecutive synchronised samples of the opposite value. Edge = cycle the filtered level changes.
- Length counter: counts cycles the filtered level has been stable, saturating at all-ones; restarts on every edge. L = value at edge. In window for X means X-MARGIN <= L <= X+MARGIN.
- States (state_out): IDLE=0, SYNC_B=1, SYNC_S=2, BIT_B=3, BIT_S=4, REP_B=5, CHECK=6.
- IDLE: on falling edge -> SYNC_B, error_out<=0, bit count and shift register cleared. A line already low on entry does not start a frame.
- SYNC_B: on rising edge with L in SBD -> SYNC_S; else error 1.
- SYNC_S: on falling edge with L in SSD -> BIT_B; L in RSD -> REP_B; else error 2.
- BIT_B: on rising edge with L in BBD -> BIT_S; else error 3.
- BIT_S: on falling edge with L in BSD0 shift in 0, L in BSD1 shift in 1, else error 4; the bit count increments; at count==NBITS -> CHECK, else -> BIT_B.
- CHECK (one cycle): if INV_CHECK && NBITS==32 && inverse test fails -> error 5, code_out unchanged. Otherwise code_out<=word, new_code_out pulse, have_code<=1, hold counter<=0 -> IDLE.
- REP_B: on rising edge with L in BBD: if have_code and hold counter <= REP_WIN then repeat_out pulse, hold counter<=0; else error 6. Out-of-window burst is error 3. -> IDLE.
- Timeout: in any non-IDLE state, counter exceeding the largest allowed max for that state without an edge raises that state's error code (SYNC_S uses SSD+MARGIN).
- Every error: error_out<=code, have_code<=0, -> IDLE the next cycle.
- Hold counter: saturating; runs whenever have_code=1.
- Error 7 is reserved and never driven.

## Timing
- Raw-to-filtered latency: 2+FILT cycles.
- FSM acts in the edge cycle; new_code_out is high one cycle after CHECK entry, code_out valid in the same cycle and held.
- repeat_out is high exactly one cycle after the REP_B rising edge.
- Reset (async assert, sync release): state IDLE, code_out=0, new_code_out=0, repeat_out=0, error_out=0, state_out=0, have_code=0, filtered level=1, counters=0.
- Reset mid-frame discards the partial frame; no pulse is emitted.
- new_code_out and repeat_out are never high in the same cycle.

## Test plan
(SBD=100, SSD=50, RSD=25, BBD=10, BSD0=10, BSD1=30, MARGIN=3, FILT=2, REP_WIN=2000, NBITS=32, MSB first)
- Valid frame 0x00FF20DF -> code_out=0x00FF20DF, single-cycle new_code_out, error_out=0, state back to 0.
- Frame 0x00FF20DE -> error_out=5, no new_code_out, code_out keeps its previous value.
- Repeat frame (100 low/25 high/10 low) 500 cycles after a valid frame -> one repeat_out pulse. Same frame at 2500 cycles, or after reset -> error_out=6.
- 1-cycle low glitch while idle -> no state change. Sync burst held 110 cycles -> error_out=1 at counter 104, IDLE.
- Bit silence of 20 cycles -> error_out=4. LSB_FIRST=1 with the wire order of 0x00FF20DF -> code_out is the bit-reversed word.
- rst_n_in pulsed low at bit 17 -> all outputs 0 asynchronously. The next full frame decodes correctly.
